cmd_sched: RTL and testbench

- Scheduler for the 256-entry command registry RAM (338-bit records, written by the command writer).
- Continuously scans the registry. When a record's TIME_START is due against the system time, it hands the record to the pulse generator over a valid/ready interface, then marks the slot empty.
- Owns the registry write port and arbitrates it between host (writer) writes and its own slot clears.

---
 rtl/cmd_sched_pkg.sv | 59 +++++
 rtl/cmd_sched_wrarb.sv | 40 ++++
 rtl/cmd_sched.sv | 177 +++++++++++++++++
 tb/tb_cmd_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command registry scheduler: record layout, empty-slot marker, FSM states.
// The optional late-drop build (CMD_SCHED_LATE_DROP_EN) uses LATE_MARGIN from here.
package cmd_sched_pkg;

  localparam int CS_N_IDX  = 256;
  localparam int CS_AW     = 8;
  localparam int CS_DW     = 338;
  localparam int CS_RD_LAT = 2;

  localparam logic [63:0] LATE_MARGIN = 64'd1000;

  localparam int TS_LSB     = 274;
  localparam int TS_W       = 64;
  localparam int FREQ_LSB   = 226;
  localparam int FREQ_W     = 48;
  localparam int FSTEP_LSB  = 178;
  localparam int FSTEP_W    = 48;
  localparam int FRATE_LSB  = 146;
  localparam int FRATE_W    = 32;
  localparam int NIMP_LSB   = 130;
  localparam int NIMP_W     = 16;
  localparam int TYPE_LSB   = 128;
  localparam int TYPE_W     = 2;
  localparam int TI_LSB     = 96;
  localparam int TP_LSB     = 64;
  localparam int TBL1_LSB   = 32;
  localparam int TBL2_LSB   = 0;
  localparam int TIMING_W   = 32;

  localparam logic [63:0] EMPTY_TS = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] time_start;
    logic [47:0] freq;
    logic [47:0] freq_step;
    logic [31:0] freq_rate;
    logic [15:0] n_impulse;
    logic [1:0]  rec_type;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_ISSUE = 3'd4,
    ST_CLEAR = 3'd5,
    ST_NEXT  = 3'd6
  } state_t;

  function automatic logic rec_is_due(input logic [63:0] ts, input logic [63:0] now);
    return (ts != EMPTY_TS) && (ts <= now);
  endfunction

endpackage

// File: rtl/cmd_sched_wrarb.sv
// Registry write-port mux: host writes win outright, scheduler clears go only on idle cycles.
// Also flags a host write landing on the slot the scheduler is currently working on.
module cmd_sched_wrarb
  import cmd_sched_pkg::*;
#(
  parameter int AW = CS_AW,
  parameter int DW = CS_DW
) (
  input  logic          i_host_wr,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_data,
  input  logic          i_clr_req,
  input  logic [AW-1:0] i_clr_addr,
  output logic          o_clr_grant,
  output logic          o_stale_hit,
  output logic          o_mem_wren,
  output logic [AW-1:0] o_mem_wraddr,
  output logic [DW-1:0] o_mem_data
);

  // Priority mux and same-slot detect.
  always_comb begin
    o_clr_grant = i_clr_req & ~i_host_wr;
    o_stale_hit = i_host_wr & (i_host_addr == i_clr_addr);
    if (i_host_wr) begin
      o_mem_wren   = 1'b1;
      o_mem_wraddr = i_host_addr;
      o_mem_data   = i_host_data;
    end else if (i_clr_req) begin
      o_mem_wren   = 1'b1;
      o_mem_wraddr = i_clr_addr;
      o_mem_data   = {EMPTY_TS, {(DW-64){1'b0}}};
    end else begin
      o_mem_wren   = 1'b0;
      o_mem_wraddr = {AW{1'b0}};
      o_mem_data   = {DW{1'b0}};
    end
  end

endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: sweeps the command registry, hands due records downstream and empties their slots.
// Build option CMD_SCHED_LATE_DROP_EN drops records older than LATE_MARGIN and pulses o_late_pulse.
module cmd_sched
  import cmd_sched_pkg::*;
#(
  parameter int N_IDX  = CS_N_IDX,
  parameter int AW     = CS_AW,
  parameter int DW     = CS_DW,
  parameter int RD_LAT = CS_RD_LAT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic [63:0]   i_time_now,
  input  logic          i_host_wr,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_data,
  output logic [AW-1:0] o_mem_rdaddr,
  output logic          o_mem_rden,
  input  logic [DW-1:0] i_mem_q,
  output logic [AW-1:0] o_mem_wraddr,
  output logic          o_mem_wren,
  output logic [DW-1:0] o_mem_data,
  output logic [DW-1:0] o_cmd_data,
  output logic          o_cmd_valid,
  input  logic          i_cmd_ready,
  output logic          o_busy,
  output logic          o_late_pulse
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_ptr, w_ptr_nx;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_nx;
  logic [DW-1:0] r_rec, w_rec_nx;
  logic          r_stale, w_stale_nx;
  logic          r_rden, r_cmd_valid, r_busy;
  logic          w_clr_req, w_clr_grant, w_stale_hit;
  logic [63:0]   w_ts;
  logic          w_due, w_stale_any;

  assign w_ts        = r_rec[TS_LSB +: TS_W];
  assign w_due       = rec_is_due(w_ts, i_time_now);
  assign w_stale_any = r_stale | w_stale_hit;
  assign w_clr_req   = (r_state == ST_CLEAR) & ~r_stale;

`ifdef CMD_SCHED_LATE_DROP_EN
  logic r_late, w_late_nx, w_too_late;
  assign w_too_late   = (i_time_now - w_ts) > LATE_MARGIN;
  assign o_late_pulse = r_late;
`else
  assign o_late_pulse = 1'b0;
`endif

  cmd_sched_wrarb #(.AW(AW), .DW(DW)) u_wrarb (
    .i_host_wr    (i_host_wr),
    .i_host_addr  (i_host_addr),
    .i_host_data  (i_host_data),
    .i_clr_req    (w_clr_req),
    .i_clr_addr   (r_ptr),
    .o_clr_grant  (w_clr_grant),
    .o_stale_hit  (w_stale_hit),
    .o_mem_wren   (o_mem_wren),
    .o_mem_wraddr (o_mem_wraddr),
    .o_mem_data   (o_mem_data)
  );

  // Next-state logic; the stale flag spans RD through CLEAR of one slot visit.
  always_comb begin
    w_state_nx    = r_state;
    w_ptr_nx      = r_ptr;
    w_wait_cnt_nx = r_wait_cnt;
    w_rec_nx      = r_rec;
    w_stale_nx    = r_stale;
`ifdef CMD_SCHED_LATE_DROP_EN
    w_late_nx     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_state_nx = ST_RD;
        else          w_state_nx = ST_IDLE;
      end
      ST_RD: begin
        // A host write racing the read itself may or may not be seen by the RAM.
        w_stale_nx    = w_stale_hit;
        w_wait_cnt_nx = {CW{1'b0}};
        w_state_nx    = ST_WAIT;
      end
      ST_WAIT: begin
        w_stale_nx = w_stale_any;
        if (r_wait_cnt == WAIT_LAST) begin
          w_rec_nx   = i_mem_q;
          w_state_nx = ST_CHECK;
        end else begin
          w_wait_cnt_nx = r_wait_cnt + CW'(1);
        end
      end
      ST_CHECK: begin
        if (w_stale_any) begin
          w_stale_nx = 1'b0;
          w_state_nx = i_enable ? ST_RD : ST_IDLE;
        end else if (!w_due) begin
          w_state_nx = ST_NEXT;
`ifdef CMD_SCHED_LATE_DROP_EN
        end else if (w_too_late) begin
          w_late_nx  = 1'b1;
          w_state_nx = ST_CLEAR;
`endif
        end else begin
          w_state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_stale_nx = w_stale_any;
        if (i_cmd_ready) w_state_nx = ST_CLEAR;
        else             w_state_nx = ST_ISSUE;
      end
      ST_CLEAR: begin
        if (w_stale_any) begin
          w_stale_nx = 1'b0;
          w_state_nx = i_enable ? ST_RD : ST_IDLE;
        end else if (w_clr_grant) begin
          w_state_nx = ST_NEXT;
        end else begin
          w_state_nx = ST_CLEAR;
        end
      end
      ST_NEXT: begin
        w_stale_nx = 1'b0;
        w_ptr_nx   = (r_ptr == AW'(N_IDX - 1)) ? {AW{1'b0}} : r_ptr + AW'(1);
        w_state_nx = i_enable ? ST_RD : ST_IDLE;
      end
      default: begin
        w_stale_nx = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, pointer, captured record and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= {AW{1'b0}};
      r_wait_cnt  <= {CW{1'b0}};
      r_rec       <= {DW{1'b0}};
      r_stale     <= 1'b0;
      r_rden      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CMD_SCHED_LATE_DROP_EN
      r_late      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_wait_cnt  <= w_wait_cnt_nx;
      r_rec       <= w_rec_nx;
      r_stale     <= w_stale_nx;
      r_rden      <= (w_state_nx == ST_RD);
      r_cmd_valid <= (w_state_nx == ST_ISSUE);
      r_busy      <= (w_state_nx != ST_IDLE);
`ifdef CMD_SCHED_LATE_DROP_EN
      r_late      <= w_late_nx;
`endif
    end
  end

  assign o_mem_rdaddr = r_ptr;
  assign o_mem_rden   = r_rden;
  assign o_cmd_data   = r_rec;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched with a latency-2 registry model and an issue scoreboard.
`timescale 1ns/1ps
module tb_cmd_sched;

  localparam int AW = 8;
  localparam int DW = 338;
  localparam int N  = 256;
  localparam logic [DW-1:0] TB_EMPTY = {64'hFFFF_FFFF_FFFF_FFFF, 274'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, host_wr, cmd_ready;
  logic [63:0]   tnow;
  logic [AW-1:0] host_addr, rdaddr, wraddr;
  logic [DW-1:0] host_data, mem_q, wdata, cmd_data;
  logic          rden, wren, cmd_valid, busy, late;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_s1, rd_s2;
  logic          mem_init;
  assign mem_q = rd_s2;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < N; i++) mem[i] <= TB_EMPTY;
    end else if (wren) begin
      mem[wraddr] <= wdata;
    end
    if (rden) rd_s1 <= mem[rdaddr];
    rd_s2 <= rd_s1;
  end

  cmd_sched dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_time_now   (tnow),
    .i_host_wr    (host_wr),
    .i_host_addr  (host_addr),
    .i_host_data  (host_data),
    .o_mem_rdaddr (rdaddr),
    .o_mem_rden   (rden),
    .i_mem_q      (mem_q),
    .o_mem_wraddr (wraddr),
    .o_mem_wren   (wren),
    .o_mem_data   (wdata),
    .o_cmd_data   (cmd_data),
    .o_cmd_valid  (cmd_valid),
    .i_cmd_ready  (cmd_ready),
    .o_busy       (busy),
    .o_late_pulse (late)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_rec(input logic [63:0] ts);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    r[337:274] = ts;
    return r;
  endfunction

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr = 1'b1; host_addr = a; host_data = d;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_valid) begin ok = 1'b1; break; end
    end
    chk({tag, "_seen"}, ok, 1);
  endtask

  task automatic sb_pop(input string tag);
    logic [DW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk(tag, cmd_data, e);
  endtask

  logic [DW-1:0] r5, r10, r7a, r7b, r20, r40, r30, r50;
  bit ok, first, done, wrap_seen, int_checked, stable, noclr;
  int a0, c0, pc, pa, sweep, nv, nl;

  initial begin
    rst_n = 1'b0; enable = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0;
    cmd_ready = 1'b1; tnow = 64'd0; mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rden", rden, 0);
    chk("rst_wren", wren, 0);
    chk("rst_rdaddr", rdaddr, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_late", late, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Slot 5 due at 100 while time ramps up from 0
    r5 = mk_rec(64'd100);
    host_write(8'd5, r5);
    exp_q.push_back(r5);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_valid) begin ok = 1'b1; break; end
      if (tnow < 64'd1050) tnow = tnow + 64'd1;
    end
    chk("A_seen", ok, 1);
    chk("A_time_due", (tnow >= 64'd100), 1);
    chk("A_addr", rdaddr, 5);
    sb_pop("A_data");
    repeat (4) @(negedge clk);
    chk("A_cleared", mem[5], TB_EMPTY);

    // Sweep of empty registry: per-slot period, wrap, full sweep length
    first = 1'b1; done = 1'b0; wrap_seen = 1'b0; int_checked = 1'b0; sweep = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (rden) begin
        if (first) begin
          a0 = int'(rdaddr); c0 = c; pc = c; pa = int'(rdaddr); first = 1'b0;
        end else begin
          if (!int_checked) begin chk("S_interval", c - pc, 5); int_checked = 1'b1; end
          if (pa == 255) begin chk("S_wrap", rdaddr, 0); wrap_seen = 1'b1; end
          if (int'(rdaddr) == a0) begin sweep = c - c0; done = 1'b1; end
          pc = c; pa = int'(rdaddr);
        end
      end
    end
    chk("S_wrap_seen", wrap_seen, 1);
    chk("S_sweep", sweep, 256 * 5);

    // READY held low for 20 cycles
    cmd_ready = 1'b0;
    r10 = mk_rec(64'd1000);
    host_write(8'd10, r10);
    exp_q.push_back(r10);
    wait_valid("B", 2000, ok);
    stable = 1'b1; noclr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(cmd_valid === 1'b1 && cmd_data === r10)) stable = 1'b0;
      if (wren !== 1'b0) noclr = 1'b0;
    end
    chk("B_stable", stable, 1);
    chk("B_no_clear", noclr, 1);
    cmd_ready = 1'b1;
    sb_pop("B_data");
    repeat (4) @(negedge clk);
    chk("B_cleared", mem[10], TB_EMPTY);

    // Host write to slot 7 during the scheduler's clear of slot 7
    r7a = mk_rec(64'd1040);
    r7b = mk_rec(64'd50);
    host_write(8'd7, r7a);
    exp_q.push_back(r7a);
    exp_q.push_back(r7b);
    wait_valid("C1", 2000, ok);
    chk("C1_addr", rdaddr, 7);
    sb_pop("C1_data");
    @(posedge clk); #1;
    host_wr = 1'b1; host_addr = 8'd7; host_data = r7b;
    @(negedge clk);
    chk("C_wren", wren, 1);
    chk("C_wdata", wdata, r7b);
    @(posedge clk); #1;
    host_wr = 1'b0;
    wait_valid("C2", 50, ok);
    chk("C2_addr", rdaddr, 7);
    sb_pop("C2_data");
    repeat (4) @(negedge clk);
    chk("C_cleared", mem[7], TB_EMPTY);

    // Reset in the middle of a handshake
    cmd_ready = 1'b0;
    r20 = mk_rec(64'd1045);
    host_write(8'd20, r20);
    exp_q.push_back(r20);
    wait_valid("D1", 2000, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("D_rst_valid", cmd_valid, 0);
    chk("D_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    chk("D_kept", mem[20], r20);
    wait_valid("D2", 2000, ok);
    chk("D2_addr", rdaddr, 20);
    sb_pop("D2_data");
    repeat (4) @(negedge clk);
    chk("D_cleared", mem[20], TB_EMPTY);

    // Very late record
    tnow = 64'd5000;
    r40 = mk_rec(64'd0);
    host_write(8'd40, r40);
    nv = 0; nl = 0;
`ifdef CMD_SCHED_LATE_DROP_EN
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (cmd_valid) nv++;
      if (late) nl++;
    end
    chk("L_no_valid", nv, 0);
    chk("L_pulses", nl, 1);
`else
    exp_q.push_back(r40);
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (late) nl++;
      if (cmd_valid) begin
        nv++;
        chk("L_addr", rdaddr, 40);
        sb_pop("L_data");
      end
    end
    chk("L_issued", nv, 1);
    chk("L_no_pulse", nl, 0);
`endif
    chk("L_cleared", mem[40], TB_EMPTY);

    // TIME_START equal to TIME_NOW is due
    r30 = mk_rec(64'd5000);
    host_write(8'd30, r30);
    exp_q.push_back(r30);
    wait_valid("E", 1500, ok);
    chk("E_addr", rdaddr, 30);
    sb_pop("E_data");

    // Time at all-ones: only the near-empty stamp is due, empty slots never
    tnow = 64'hFFFF_FFFF_FFFF_FFFF;
    r50 = mk_rec(64'hFFFF_FFFF_FFFF_FFFE);
    host_write(8'd50, r50);
    exp_q.push_back(r50);
    nv = 0;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        nv++;
        sb_pop("F_data");
      end
    end
    chk("F_issue_count", nv, 1);
    chk("Q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
